// File: rtl/service_pkg.sv
// Shared definitions for the countdown service: FSM state encoding,
// BCD digit limits, MM:SS field offsets and a digit clamp helper.
package service_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_ALARM = 3'd4
  } state_e;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  // Bit offsets of each BCD digit inside the 16-bit MM:SS word.
  localparam int MIN_TENS_LSB = 12;
  localparam int MIN_ONES_LSB = 8;
  localparam int SEC_TENS_LSB = 4;
  localparam int SEC_ONES_LSB = 0;

  // Clamp every nibble of an MM:SS word to a legal BCD digit (>9 becomes 9).
  // Seconds tens above 5 are deliberately left alone; they count down as-is.
  function automatic logic [15:0] bcd_clamp_mmss(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    for (int i = 0; i < 4; i++) begin
      if (t[i*4 +: 4] > BCD_MAX) begin
        r[i*4 +: 4] = BCD_MAX;
      end else begin
        r[i*4 +: 4] = t[i*4 +: 4];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_mmss_dec.sv
// Combinational one-second decrement of a BCD MM:SS word, plus a flag that
// the decremented result is 00:00.
module bcd_mmss_dec
  import service_pkg::*;
(
  input  logic [15:0] mmss_i,
  output logic [15:0] dec_o,
  output logic        zero_o
);

  logic [3:0] so_s, st_s, mo_s, mt_s;
  logic [3:0] so_d, st_d, mo_d, mt_d;

  assign so_s = mmss_i[SEC_ONES_LSB +: 4];
  assign st_s = mmss_i[SEC_TENS_LSB +: 4];
  assign mo_s = mmss_i[MIN_ONES_LSB +: 4];
  assign mt_s = mmss_i[MIN_TENS_LSB +: 4];

  // Ripple a borrow from seconds ones up to minute tens; seconds wrap 00->59.
  always_comb begin
    so_d = so_s;
    st_d = st_s;
    mo_d = mo_s;
    mt_d = mt_s;
    if (so_s != 4'd0) begin
      so_d = so_s - 4'd1;
    end else begin
      so_d = BCD_MAX;
      if (st_s != 4'd0) begin
        st_d = st_s - 4'd1;
      end else begin
        st_d = SEC_TENS_MAX;
        if (mo_s != 4'd0) begin
          mo_d = mo_s - 4'd1;
        end else begin
          mo_d = BCD_MAX;
          if (mt_s != 4'd0) begin
            mt_d = mt_s - 4'd1;
          end else begin
            mt_d = BCD_MAX;
          end
        end
      end
    end
  end

  assign dec_o  = {mt_d, mo_d, st_d, so_d};
  assign zero_o = (dec_o == 16'h0000);

endmodule

// File: rtl/service_1_countdown_ctrl.sv
// Countdown timer controller: IDLE/READY/RUN/PAUSE/ALARM FSM, one-second
// prescaler, alarm duration counter and display digit enables.
// Optional build macro SERVICE_1_PAUSE_BLINK_EN makes the display blink at
// half-second rate while paused; without it the display stays lit in PAUSE.
module service_1_countdown_ctrl
  import service_pkg::*;
#(
  parameter int CLK_HZ    = 100000000,
  parameter int ALARM_SEC = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] time_in,
  input  logic        start_stop,
  input  logic        clear,
  output logic [15:0] num,
  output logic [3:0]  sel,
  output logic [2:0]  state,
  output logic        alarm,
  output logic        done
);

  localparam int            PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
  localparam logic [3:0]    ALARM_LAST = 4'(ALARM_SEC - 1);

  state_e        state_q, state_d;
  logic [15:0]   num_q, num_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    acnt_q, acnt_d;
  logic          done_q, done_d;
  logic          alarm_q, alarm_d;
  logic [3:0]    sel_q, sel_d;

  logic          tick_s;
  logic [15:0]   load_val_s;
  logic [15:0]   dec_num_s;
  logic          dec_zero_s;
  logic          blink_off_s;

  assign tick_s     = (presc_q == PRESC_MAX);
  assign load_val_s = bcd_clamp_mmss(time_in);

  bcd_mmss_dec u_dec (
    .mmss_i (num_q),
    .dec_o  (dec_num_s),
    .zero_o (dec_zero_s)
  );

  // Next-state and remaining-time logic; clear beats load beats start_stop.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    done_d  = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      num_d   = 16'h0000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            num_d   = load_val_s;
            state_d = (load_val_s == 16'h0000) ? ST_IDLE : ST_READY;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_READY, ST_PAUSE: begin
          if (load) begin
            num_d   = load_val_s;
            state_d = (load_val_s == 16'h0000) ? ST_IDLE : ST_READY;
          end else if (start_stop) begin
            state_d = ST_RUN;
          end else begin
            state_d = state_q;
          end
        end
        ST_RUN: begin
          // A load in RUN is ignored but still masks start_stop that cycle.
          if (tick_s) begin
            num_d = dec_num_s;
          end else begin
            num_d = num_q;
          end
          if (tick_s && dec_zero_s) begin
            state_d = ST_ALARM;
            done_d  = 1'b1;
          end else if (start_stop && !load) begin
            state_d = ST_PAUSE;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_ALARM: begin
          if (load) begin
            num_d   = load_val_s;
            state_d = (load_val_s == 16'h0000) ? ST_IDLE : ST_READY;
          end else if (start_stop) begin
            state_d = ST_IDLE;
          end else if (tick_s && (acnt_q == ALARM_LAST)) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ALARM;
          end
        end
        default: begin
          state_d = ST_IDLE;
          num_d   = 16'h0000;
        end
      endcase
    end
  end

  // Prescaler: zero in IDLE/READY, free-run in RUN/ALARM, frozen in PAUSE.
  always_comb begin
    presc_d = presc_q;
    if ((state_d == ST_IDLE) || (state_d == ST_READY)) begin
      presc_d = '0;
    end else if ((state_q == ST_RUN) || (state_q == ST_ALARM)) begin
      if (tick_s) begin
        presc_d = '0;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else begin
      presc_d = presc_q;
    end
  end

  // Count elapsed seconds while staying in ALARM; restarts on every entry.
  always_comb begin
    acnt_d = 4'd0;
    if ((state_q == ST_ALARM) && (state_d == ST_ALARM)) begin
      if (tick_s) begin
        acnt_d = acnt_q + 4'd1;
      end else begin
        acnt_d = acnt_q;
      end
    end else begin
      acnt_d = 4'd0;
    end
  end

`ifdef SERVICE_1_PAUSE_BLINK_EN
  localparam int            HALF      = ((CLK_HZ / 2) > 1) ? (CLK_HZ / 2) : 1;
  localparam int            BW        = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [BW-1:0] HALF_LAST = BW'(HALF - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;

  // Half-second blink timer, restarted lit on every PAUSE entry.
  always_comb begin
    blink_cnt_d   = '0;
    blink_phase_d = 1'b0;
    if ((state_q == ST_PAUSE) && (state_d == ST_PAUSE)) begin
      if (blink_cnt_q == HALF_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_q + BW'(1);
        blink_phase_d = blink_phase_q;
      end
    end else begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end
  end

  // Blink timer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign blink_off_s = blink_phase_d;
`else
  assign blink_off_s = 1'b0;
`endif

  // Registered output decode driven from the next state.
  always_comb begin
    alarm_d = (state_d == ST_ALARM);
    sel_d   = 4'b1111;
    case (state_d)
      ST_IDLE:  sel_d = 4'b0000;
      ST_PAUSE: sel_d = blink_off_s ? 4'b0000 : 4'b1111;
      default:  sel_d = 4'b1111;
    endcase
  end

  // State, time, prescaler and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      num_q   <= 16'h0000;
      presc_q <= '0;
      acnt_q  <= 4'd0;
      done_q  <= 1'b0;
      alarm_q <= 1'b0;
      sel_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      presc_q <= presc_d;
      acnt_q  <= acnt_d;
      done_q  <= done_d;
      alarm_q <= alarm_d;
      sel_q   <= sel_d;
    end
  end

  assign num   = num_q;
  assign sel   = sel_q;
  assign state = state_q;
  assign alarm = alarm_q;
  assign done  = done_q;

endmodule

// File: tb/tb_service_1_countdown_ctrl.sv
// Directed testbench for service_1_countdown_ctrl with CLK_HZ=10, ALARM_SEC=2.
module tb_service_1_countdown_ctrl;

  logic        clk;
  logic        reset;
  logic        load;
  logic [15:0] time_in;
  logic        start_stop;
  logic        clear;
  logic [15:0] num;
  logic [3:0]  sel;
  logic [2:0]  state;
  logic        alarm;
  logic        done;

  int n_vec;
  int n_err;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READY = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_ALARM = 3'd4;

  service_1_countdown_ctrl #(.CLK_HZ(10), .ALARM_SEC(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .time_in    (time_in),
    .start_stop (start_stop),
    .clear      (clear),
    .num        (num),
    .sel        (sel),
    .state      (state),
    .alarm      (alarm),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [15:0] v);
    time_in = v;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start_stop = 1'b1;
    cyc(1);
    start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    load = 1'b0;
    time_in = 16'h0000;
    start_stop = 1'b0;
    clear = 1'b0;

    // Reset state
    #23;
    check_eq("rst_num", 32'(num), 32'h0000);
    check_eq("rst_state", 32'(state), 32'(S_IDLE));
    check_eq("rst_sel", 32'(sel), 32'h0);
    check_eq("rst_alarm", 32'(alarm), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);
    reset = 1'b1;
    cyc(1);

    // 00:03 countdown into ALARM
    pulse_load(16'h0003);
    check_eq("ld3_state", 32'(state), 32'(S_READY));
    check_eq("ld3_sel", 32'(sel), 32'hF);
    pulse_start();
    check_eq("run_state", 32'(state), 32'(S_RUN));
    cyc(9);
    check_eq("pre_tick", 32'(num), 32'h0003);
    cyc(1);
    check_eq("dec_0002", 32'(num), 32'h0002);
    cyc(10);
    check_eq("dec_0001", 32'(num), 32'h0001);
    cyc(10);
    check_eq("dec_0000", 32'(num), 32'h0000);
    check_eq("alm_state", 32'(state), 32'(S_ALARM));
    check_eq("done_pulse", 32'(done), 32'h1);
    check_eq("alarm_on", 32'(alarm), 32'h1);
    cyc(1);
    check_eq("done_low", 32'(done), 32'h0);
    cyc(18);
    check_eq("alm_hold", 32'(state), 32'(S_ALARM));
    cyc(1);
    check_eq("alm_exit", 32'(state), 32'(S_IDLE));
    check_eq("alm_exit_sel", 32'(sel), 32'h0);
    check_eq("alm_exit_alarm", 32'(alarm), 32'h0);

    // ALARM acknowledged by start_stop at cycle 3
    pulse_load(16'h0001);
    pulse_start();
    cyc(10);
    check_eq("alm2_state", 32'(state), 32'(S_ALARM));
    cyc(2);
    pulse_start();
    check_eq("ack_state", 32'(state), 32'(S_IDLE));
    check_eq("ack_alarm", 32'(alarm), 32'h0);

    // Minute and minute-tens borrow
    pulse_load(16'h0100);
    pulse_start();
    cyc(10);
    check_eq("borrow_0059", 32'(num), 32'h0059);
    pulse_clear();
    check_eq("clr_state", 32'(state), 32'(S_IDLE));
    check_eq("clr_num", 32'(num), 32'h0000);
    pulse_load(16'h1000);
    pulse_start();
    cyc(10);
    check_eq("borrow_0959", 32'(num), 32'h0959);
    pulse_clear();

    // Pause freezes prescaler; resume continues it
    pulse_load(16'h0005);
    pulse_start();
    cyc(3);
    pulse_start();
    check_eq("pause_state", 32'(state), 32'(S_PAUSE));
    check_eq("pause_sel0", 32'(sel), 32'hF);
`ifdef SERVICE_1_PAUSE_BLINK_EN
    cyc(4);
    check_eq("blink_on", 32'(sel), 32'hF);
    cyc(1);
    check_eq("blink_off", 32'(sel), 32'h0);
    cyc(5);
    check_eq("blink_on2", 32'(sel), 32'hF);
    cyc(40);
`else
    cyc(50);
    check_eq("pause_sel", 32'(sel), 32'hF);
`endif
    check_eq("pause_num", 32'(num), 32'h0005);
    check_eq("pause_hold", 32'(state), 32'(S_PAUSE));
    pulse_start();
    check_eq("resume_state", 32'(state), 32'(S_RUN));
    cyc(5);
    check_eq("resume_pre", 32'(num), 32'h0005);
    cyc(1);
    check_eq("resume_dec", 32'(num), 32'h0004);

    // Load handling
    pulse_load(16'h0700);
    check_eq("ld_run_state", 32'(state), 32'(S_RUN));
    check_eq("ld_run_num", 32'(num), 32'h0004);
    pulse_clear();
    pulse_load(16'hA3F7);
    check_eq("clamp_num", 32'(num), 32'h9397);
    check_eq("clamp_state", 32'(state), 32'(S_READY));
    pulse_load(16'h0000);
    check_eq("ld0_state", 32'(state), 32'(S_IDLE));
    check_eq("ld0_num", 32'(num), 32'h0000);
    pulse_load(16'h0012);
    time_in = 16'h0034;
    load = 1'b1;
    clear = 1'b1;
    cyc(1);
    load = 1'b0;
    clear = 1'b0;
    check_eq("ldclr_state", 32'(state), 32'(S_IDLE));
    check_eq("ldclr_num", 32'(num), 32'h0000);
    pulse_start();
    check_eq("idle_start", 32'(state), 32'(S_IDLE));
    pulse_load(16'h0090);
    pulse_start();
    cyc(10);
    check_eq("sec_tens9", 32'(num), 32'h0089);
    pulse_clear();

    // Asynchronous reset mid-RUN
    pulse_load(16'h0007);
    pulse_start();
    cyc(5);
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_num", 32'(num), 32'h0000);
    check_eq("arst_state", 32'(state), 32'(S_IDLE));
    #3;
    reset = 1'b1;
    cyc(1);
    pulse_start();
    check_eq("post_rst_idle", 32'(state), 32'(S_IDLE));
    pulse_load(16'h0002);
    check_eq("post_rst_ld", 32'(state), 32'(S_READY));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
